// File: rtl/rx_pkg_framer_pkg.sv
// Shared types and helpers for the rx_pkg_framer byte-stream frame extractor.
package rx_pkg_framer_pkg;

    localparam int COUNT_W = 11;

    typedef enum logic {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } fsm_state_t;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } drain_state_t;

    // Byte idx of an nbytes-wide pattern whose first byte sits in the MSB.
    function automatic logic [7:0] msb_byte(input logic [63:0] vec,
                                            input int unsigned nbytes,
                                            input int unsigned idx);
        if (nbytes > 8 || idx >= nbytes) return 8'h00;
        return vec[8*(nbytes-1-idx) +: 8];
    endfunction

endpackage

// File: rtl/rx_pkg_sync_fifo.sv
// Byte-wide synchronous FIFO with first-word fall-through read; DEPTH must be a power of 2.
module rx_pkg_sync_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       push_i,
    input  logic [7:0] din_i,
    input  logic       pop_i,
    output logic [7:0] dout_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign empty_o = (wr_ptr == rd_ptr);
    assign full_o  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout_o  = mem[rd_ptr[AW-1:0]];

    // A full FIFO may still take a byte when the same clock frees a slot.
    assign do_push = push_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o;

    // NOTE: storage is deliberately left out of reset; only the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din_i;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/rx_pkg_framer.sv
// SOF-hunting frame extractor with byte substitution, field pick and burst replay.
// Defining RX_PKG_STATS_EN adds saturating frames_ok_o / frames_drop_o counters.
module rx_pkg_framer
    import rx_pkg_framer_pkg::*;
#(
    parameter logic                    TOGGLE             = 1'b0,
    parameter int                      FIFO_DEPTH         = 16,
    parameter int                      FIFO_BUFFER_DEP    = 256,
    parameter int                      SOF_LENGTH         = 6,
    parameter logic [8*SOF_LENGTH-1:0] SOF_PATTERN        = 48'h244750474741,
    parameter logic                    EOF_DETECTION      = 1'b1,
    parameter int                      EOF_LENGTH         = 1,
    parameter logic [8*EOF_LENGTH-1:0] EOF_PATTERN        = 8'h0A,
    parameter logic                    FRAME_LENGTH_FIXED = 1'b0,
    parameter int                      FRAME_CNT          = 67,
    parameter logic                    SUB                = 1'b1,
    parameter int                      SUB_POS            = 7,
    parameter int                      SUB_LENGTH         = 9,
    parameter int                      PICK_POS           = 17,
    parameter int                      PICK_LENGTH        = 9
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     enable_i,
    input  logic                     rx_datavld_i,
    input  logic [7:0]               rx_data_i,
    input  logic                     sub_datavld_i,
    input  logic [8*SUB_LENGTH-1:0]  sub_data_i,
    output logic [8*PICK_LENGTH-1:0] pick_data_o,
    output logic                     pick_datavld_o,
    output logic                     FIFO_clear_o,
    output logic                     frame_datavld_o,
    output logic [7:0]               frame_data_o,
    output logic [COUNT_W-1:0]       frame_cnt_o,
    output logic                     frame_interrupt_o
`ifdef RX_PKG_STATS_EN
    ,
    output logic [15:0]              frames_ok_o,
    output logic [15:0]              frames_drop_o
`endif
);

    localparam int SW  = 8 * SOF_LENGTH;
    localparam int EW  = 8 * EOF_LENGTH;
    localparam int SBW = 8 * SUB_LENGTH;
    localparam int PW  = 8 * PICK_LENGTH;
    localparam int IW  = $clog2(FIFO_BUFFER_DEP);
    localparam int AW  = IW + (TOGGLE ? 1 : 0);

    localparam logic [COUNT_W-1:0] CNT_SOF   = COUNT_W'(SOF_LENGTH);
    localparam logic [COUNT_W-1:0] CNT_FIX   = COUNT_W'(FRAME_CNT);
    localparam logic [COUNT_W-1:0] CNT_MAX   = COUNT_W'(FIFO_BUFFER_DEP);
    localparam logic [COUNT_W-1:0] SUB_LO    = COUNT_W'(SUB_POS);
    localparam logic [COUNT_W-1:0] SUB_HI    = COUNT_W'(SUB_POS + SUB_LENGTH);
    localparam logic [COUNT_W-1:0] PICK_LO   = COUNT_W'(PICK_POS);
    localparam logic [COUNT_W-1:0] PICK_LAST = COUNT_W'(PICK_POS + PICK_LENGTH - 1);

    if (FIFO_BUFFER_DEP > 2047 || SUB_POS + SUB_LENGTH > FIFO_BUFFER_DEP ||
        PICK_POS + PICK_LENGTH > FIFO_BUFFER_DEP) begin : g_bad_cfg
        $error("rx_pkg_framer: buffer depth or field range exceeds the 11-bit frame count");
    end

    fsm_state_t         state;
    drain_state_t       drain_state;
    logic [COUNT_W-1:0] count;
    logic [COUNT_W-1:0] new_count;
    logic [COUNT_W-1:0] drain_idx;
    logic [COUNT_W-1:0] drain_len;
    logic               wr_bank;
    logic               drain_bank;
    logic [SW-1:0]      sof_sr;
    logic [SW-1:0]      sof_next;
    logic [EW-1:0]      eof_sr;
    logic [EW-1:0]      eof_next;
    logic [SBW-1:0]     sub_reg;
    logic [SBW-1:0]     sub_shift;
    logic               sub_active;
    logic               sub_frame;
    logic [PW-1:0]      pick_sr;
    logic [PW-1:0]      pick_next;
    logic [7:0]         buf_mem [2**AW];
    logic [AW-1:0]      wr_addr;
    logic [AW-1:0]      rd_addr;

    logic       push;
    logic       pop;
    logic       overflow;
    logic [7:0] rx_byte;
    logic [7:0] wr_byte;
    logic       fifo_full;
    logic       fifo_empty;
    logic       in_sub;
    logic       in_pick;
    logic       sof_hit;
    logic       frame_end;
    logic       wr_en;

    rx_pkg_sync_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_stage_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .push_i    (push),
        .din_i     (rx_data_i),
        .pop_i     (pop),
        .dout_o    (rx_byte),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign push     = rx_datavld_i && enable_i;
    assign pop      = !fifo_empty;
    assign overflow = push && fifo_full && !pop;
    assign wr_addr  = AW'({wr_bank, count[IW-1:0]});
    assign rd_addr  = AW'({drain_bank, drain_idx[IW-1:0]});

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        sof_next  = SW'({sof_sr, rx_byte});
        in_sub    = SUB && sub_frame && (count >= SUB_LO) && (count < SUB_HI);
        wr_byte   = in_sub ? sub_shift[SBW-1 -: 8] : rx_byte;
        eof_next  = EW'({eof_sr, wr_byte});
        in_pick   = (count >= PICK_LO) && (count <= PICK_LAST);
        pick_next = PW'({pick_sr, rx_byte});
        new_count = count + 1'b1;
        wr_en     = pop && (state == COLLECT);
        // Single-buffer mode must not overwrite a bank that is still replaying.
        sof_hit   = (sof_next == SOF_PATTERN) && (TOGGLE || drain_state == IDLE);
        frame_end = 1'b0;
        if (FRAME_LENGTH_FIXED) frame_end = (new_count == CNT_FIX);
        else if (EOF_DETECTION) frame_end = (eof_next == EOF_PATTERN);
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) buf_mem[wr_addr] <= wr_byte;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state             <= HUNT;
            drain_state       <= IDLE;
            count             <= '0;
            drain_idx         <= '0;
            drain_len         <= '0;
            wr_bank           <= 1'b0;
            drain_bank        <= 1'b0;
            sof_sr            <= '0;
            eof_sr            <= '0;
            sub_reg           <= '0;
            sub_shift         <= '0;
            sub_active        <= 1'b0;
            sub_frame         <= 1'b0;
            pick_sr           <= '0;
            pick_data_o       <= '0;
            pick_datavld_o    <= 1'b0;
            FIFO_clear_o      <= 1'b0;
            frame_datavld_o   <= 1'b0;
            frame_data_o      <= '0;
            frame_cnt_o       <= '0;
            frame_interrupt_o <= 1'b0;
        end else begin
            pick_datavld_o    <= 1'b0;
            frame_interrupt_o <= 1'b0;
            FIFO_clear_o      <= overflow;

            if (sub_datavld_i) begin
                sub_reg    <= sub_data_i;
                sub_active <= 1'b1;
            end

            // SOF bytes are never stored: they always equal the pattern.
            if (drain_state == DRAIN) begin
                frame_datavld_o <= 1'b1;
                frame_data_o    <= (drain_idx < CNT_SOF)
                                   ? msb_byte(64'(SOF_PATTERN), SOF_LENGTH, 32'(drain_idx))
                                   : buf_mem[rd_addr];
                drain_idx       <= drain_idx + 1'b1;
                if (drain_idx == drain_len - 1'b1) drain_state <= IDLE;
            end else begin
                frame_datavld_o <= 1'b0;
            end

            if (pop) begin
                case (state)
                    HUNT: begin
                        sof_sr <= sof_next;
                        if (sof_hit) begin
                            state     <= COLLECT;
                            count     <= CNT_SOF;
                            sof_sr    <= '0;
                            eof_sr    <= EW'(64'(SOF_PATTERN));
                            // Substitution data is snapshotted per frame so a mid-frame load cannot tear it.
                            sub_shift <= sub_reg;
                            sub_frame <= sub_active;
                        end
                    end
                    COLLECT: begin
                        count  <= new_count;
                        eof_sr <= eof_next;
                        if (in_sub) sub_shift <= sub_shift << 8;
                        if (in_pick) begin
                            pick_sr <= pick_next;
                            if (count == PICK_LAST) begin
                                pick_data_o    <= pick_next;
                                pick_datavld_o <= 1'b1;
                            end
                        end
                        if (frame_end) begin
                            state <= HUNT;
                            if (drain_state == DRAIN) begin
                                FIFO_clear_o <= 1'b1;
                            end else begin
                                frame_cnt_o       <= new_count;
                                frame_interrupt_o <= 1'b1;
                                drain_state       <= DRAIN;
                                drain_idx         <= '0;
                                drain_len         <= new_count;
                                drain_bank        <= wr_bank;
                                if (TOGGLE) wr_bank <= ~wr_bank;
                            end
                        end else if (new_count == CNT_MAX) begin
                            state        <= HUNT;
                            FIFO_clear_o <= 1'b1;
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

`ifdef RX_PKG_STATS_EN
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            frames_ok_o   <= '0;
            frames_drop_o <= '0;
        end else begin
            if (frame_interrupt_o && frames_ok_o != 16'hFFFF) frames_ok_o <= frames_ok_o + 1'b1;
            if (FIFO_clear_o && frames_drop_o != 16'hFFFF) frames_drop_o <= frames_drop_o + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_rx_pkg_framer.sv
// Scoreboard bench for rx_pkg_framer: default build (dut_a) and fixed-length build (dut_b).
module tb_rx_pkg_framer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en_a, en_b;
    logic        rx_vld;
    logic [7:0]  rx_data;
    logic        sub_vld;
    logic [71:0] sub_data;

    logic [71:0] a_pick, b_pick;
    logic        a_pickv, b_pickv, a_clr, b_clr, a_vld, b_vld, a_irq, b_irq;
    logic [7:0]  a_data, b_data;
    logic [10:0] a_cnt, b_cnt;
`ifdef RX_PKG_STATS_EN
    logic [15:0] a_ok, a_drop, b_ok, b_drop;
`endif

    always #5 clk = ~clk;

    rx_pkg_framer dut_a (
        .clk_i(clk), .reset_n_i(rst_n), .enable_i(en_a),
        .rx_datavld_i(rx_vld), .rx_data_i(rx_data),
        .sub_datavld_i(sub_vld), .sub_data_i(sub_data),
        .pick_data_o(a_pick), .pick_datavld_o(a_pickv), .FIFO_clear_o(a_clr),
        .frame_datavld_o(a_vld), .frame_data_o(a_data), .frame_cnt_o(a_cnt),
        .frame_interrupt_o(a_irq)
`ifdef RX_PKG_STATS_EN
        , .frames_ok_o(a_ok), .frames_drop_o(a_drop)
`endif
    );

    rx_pkg_framer #(.FRAME_LENGTH_FIXED(1'b1), .FRAME_CNT(67)) dut_b (
        .clk_i(clk), .reset_n_i(rst_n), .enable_i(en_b),
        .rx_datavld_i(rx_vld), .rx_data_i(rx_data),
        .sub_datavld_i(sub_vld), .sub_data_i(sub_data),
        .pick_data_o(b_pick), .pick_datavld_o(b_pickv), .FIFO_clear_o(b_clr),
        .frame_datavld_o(b_vld), .frame_data_o(b_data), .frame_cnt_o(b_cnt),
        .frame_interrupt_o(b_irq)
`ifdef RX_PKG_STATS_EN
        , .frames_ok_o(b_ok), .frames_drop_o(b_drop)
`endif
    );

    localparam string GGA = "$GPGGA,123519.00,4807.038,N\n";
    localparam logic [71:0] PICK_EXP = 72'h343830372E3033382C;
    localparam logic [71:0] SUB_VAL  = 72'h2121212121212E2121;

    int pass_cnt = 0;
    int total_cnt = 0;

    byte unsigned exp_a[$], exp_b[$];
    int           len_a[$], len_b[$];
    int irq_a = 0, irq_b = 0, clr_a = 0, clr_b = 0, pickp_a = 0;
    int run_b = 0, last_run_b = 0;

    bit          sub_active_m = 1'b0;
    logic [71:0] sub_m = '0;

    // Scoreboard monitors: sampled on the falling edge, away from DUT updates.
    always @(negedge clk) begin
        if (rst_n) begin
            if (a_irq) begin
                irq_a++;
                total_cnt++;
                if (len_a.size() == 0) $display("FAIL a_cnt unexpected interrupt cnt=%0d", a_cnt);
                else begin
                    int e;
                    e = len_a.pop_front();
                    if (a_cnt !== 11'(e)) $display("FAIL a_cnt got %0d exp %0d", a_cnt, e);
                    else pass_cnt++;
                end
            end
            if (a_vld) begin
                total_cnt++;
                if (exp_a.size() == 0) $display("FAIL a_byte unexpected byte %02h", a_data);
                else begin
                    byte unsigned e;
                    e = exp_a.pop_front();
                    if (a_data !== e) $display("FAIL a_byte got %02h exp %02h", a_data, e);
                    else pass_cnt++;
                end
            end
            if (a_clr)   clr_a++;
            if (a_pickv) pickp_a++;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (b_irq) begin
                irq_b++;
                total_cnt++;
                if (len_b.size() == 0) $display("FAIL b_cnt unexpected interrupt cnt=%0d", b_cnt);
                else begin
                    int e;
                    e = len_b.pop_front();
                    if (b_cnt !== 11'(e)) $display("FAIL b_cnt got %0d exp %0d", b_cnt, e);
                    else pass_cnt++;
                end
            end
            if (b_vld) begin
                run_b++;
                total_cnt++;
                if (exp_b.size() == 0) $display("FAIL b_byte unexpected byte %02h", b_data);
                else begin
                    byte unsigned e;
                    e = exp_b.pop_front();
                    if (b_data !== e) $display("FAIL b_byte got %02h exp %02h", b_data, e);
                    else pass_cnt++;
                end
            end else if (run_b > 0) begin
                last_run_b = run_b;
                run_b = 0;
            end
            if (b_clr) clr_b++;
        end
    end

    // Reference model: expected replay of a frame given the current substitution state.
    task automatic expect_frame(input string s, input bit to_b);
        for (int i = 0; i < s.len(); i++) begin
            byte unsigned c;
            c = s[i];
            if (sub_active_m && i >= 7 && i < 16) c = sub_m[8*(15-i) +: 8];
            if (to_b) exp_b.push_back(c);
            else      exp_a.push_back(c);
        end
        if (to_b) len_b.push_back(s.len());
        else      len_a.push_back(s.len());
    endtask

    task automatic send_byte(input byte unsigned b);
        @(negedge clk);
        rx_data = b;
        rx_vld  = 1'b1;
        @(negedge clk);
        rx_vld  = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic settle();
        repeat (320) @(negedge clk);
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        total_cnt++;
        if (got !== exp) $display("FAIL %s got %0d exp %0d", name, got, exp);
        else pass_cnt++;
    endtask

    task automatic check_drained();
        total_cnt++;
        if (exp_a.size() != 0 || len_a.size() != 0 || exp_b.size() != 0 || len_b.size() != 0)
            $display("FAIL drained got %0d/%0d/%0d/%0d pending exp 0", exp_a.size(), len_a.size(),
                     exp_b.size(), len_b.size());
        else pass_cnt++;
    endtask

    task automatic check_a_zero(input string tag);
        total_cnt++;
        if ({a_pick, a_pickv, a_clr, a_vld, a_data, a_cnt, a_irq} !== '0)
            $display("FAIL %s_a_outputs got pick=%h pv=%b clr=%b vld=%b data=%h cnt=%0d irq=%b exp 0",
                     tag, a_pick, a_pickv, a_clr, a_vld, a_data, a_cnt, a_irq);
        else pass_cnt++;
        total_cnt++;
        if ({b_pick, b_pickv, b_clr, b_vld, b_data, b_cnt, b_irq} !== '0)
            $display("FAIL %s_b_outputs got data=%h cnt=%0d irq=%b vld=%b exp 0", tag, b_data, b_cnt,
                     b_irq, b_vld);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        check_a_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_nosub();
        int i0, p0, c0;
        i0 = irq_a; p0 = pickp_a; c0 = clr_a;
        expect_frame(GGA, 1'b0);
        send_str(GGA);
        settle();
        check_int("nosub_irq", irq_a - i0, 1);
        check_int("nosub_pick_pulses", pickp_a - p0, 1);
        check_int("nosub_clear", clr_a - c0, 0);
        total_cnt++;
        if (a_pick !== PICK_EXP) $display("FAIL nosub_pick got %h exp %h", a_pick, PICK_EXP);
        else pass_cnt++;
        check_drained();
    endtask

    task automatic test_sub();
        int i0, p0;
        i0 = irq_a; p0 = pickp_a;
        @(negedge clk);
        sub_data = SUB_VAL;
        sub_vld  = 1'b1;
        @(negedge clk);
        sub_vld  = 1'b0;
        sub_data = '0;
        sub_active_m = 1'b1;
        sub_m = SUB_VAL;
        expect_frame(GGA, 1'b0);
        send_str(GGA);
        settle();
        check_int("sub_irq", irq_a - i0, 1);
        check_int("sub_pick_pulses", pickp_a - p0, 1);
        check_int("sub_cnt", a_cnt, 28);
        total_cnt++;
        if (a_pick !== PICK_EXP) $display("FAIL sub_pick got %h exp %h", a_pick, PICK_EXP);
        else pass_cnt++;
        check_drained();
    endtask

    task automatic test_junk();
        int i0;
        i0 = irq_a;
        send_str("ABC$GPGG");
        repeat (40) @(negedge clk);
        check_int("junk_no_irq", irq_a - i0, 0);
        expect_frame(GGA, 1'b0);
        send_str(GGA);
        settle();
        check_int("junk_then_frame_irq", irq_a - i0, 1);
        check_drained();
    endtask

    task automatic test_abort();
        int i0, c0;
        i0 = irq_a; c0 = clr_a;
        send_str("$GPGGA");
        for (int i = 0; i < 300; i++) send_byte(8'h78);
        settle();
        check_int("abort_clear", clr_a - c0, 1);
        check_int("abort_no_irq", irq_a - i0, 0);
        expect_frame(GGA, 1'b0);
        send_str(GGA);
        settle();
        check_int("abort_next_irq", irq_a - i0, 1);
        total_cnt++;
        if (a_pick !== PICK_EXP) $display("FAIL abort_next_pick got %h exp %h", a_pick, PICK_EXP);
        else pass_cnt++;
        check_drained();
    endtask

    task automatic test_fixed();
        string s;
        int ia0, ib0;
        ia0 = irq_a; ib0 = irq_b;
        s = "$GPGGA";
        for (int i = 6; i < 67; i++) begin
            byte unsigned c;
            c = (i == 30) ? 8'h0A : byte'(8'h30 + i % 10);
            s = {s, "?"};
            s.putc(i, c);
        end
        en_a = 1'b0;
        en_b = 1'b1;
        expect_frame(s, 1'b1);
        send_str(s);
        settle();
        en_b = 1'b0;
        en_a = 1'b1;
        check_int("fixed_irq", irq_b - ib0, 1);
        check_int("fixed_cnt", b_cnt, 67);
        check_int("fixed_run", last_run_b, 67);
        check_int("fixed_disabled_a_irq", irq_a - ia0, 0);
        check_int("fixed_clear", clr_b, 0);
        check_drained();
    endtask

    task automatic test_mid_reset();
        int i0;
        send_str("$GPGGA,1234");
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_a_zero("midreset");
        rst_n = 1'b1;
        sub_active_m = 1'b0;
        i0 = irq_a;
        repeat (40) @(negedge clk);
        check_int("midreset_no_irq", irq_a - i0, 0);
        expect_frame(GGA, 1'b0);
        send_str(GGA);
        settle();
        check_int("midreset_next_irq", irq_a - i0, 1);
        check_int("midreset_cnt", a_cnt, 28);
        check_drained();
    endtask

    initial begin
        rst_n    = 1'b0;
        en_a     = 1'b1;
        en_b     = 1'b0;
        rx_vld   = 1'b0;
        rx_data  = '0;
        sub_vld  = 1'b0;
        sub_data = '0;
        test_reset();
        test_nosub();
        test_sub();
        test_junk();
        test_abort();
        test_fixed();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
